exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Central exception sequencer for the PPC core. Arbitrates the sticky exception requests
//  (programError, TLB, storage, syscall, external) by fixed priority. Sequences the SPR saves
//  (SRR0/SRR1/ESR/DEAR), computes the vector IVPR|IVORn and redirects fetch. Also executes rfi.
//  Sits between the exception sources and the SPR file / fetch unit; stalls the pipe while busy.
// PARAMETERS
//  MSR_CLR_MASK  32'h0000_C030  MSR bits cleared on entry (EE,PR,IS,DS)
//  NSRC          7              number of exception sources (index = priority, 0 highest)
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  exc_req    in   7   sticky requests: 0 ITLB(IVOR14) 1 ISI(IVOR3) 2 PROG(IVOR6) 3 SC(IVOR8)
//                      4 DTLB(IVOR13) 5 DSI(IVOR2) 6 EXT(IVOR4)
//  exc_ack    out  7   one-hot, 1-cycle ack to served source (clears its sticky req)
//  epc        in   32  PC of faulting instruction
//  epc_next   in   32  PC following faulting instruction (SC, EXT)
//  esr_in     in   32  ESR syndrome for current request
//  dear_in    in   32  faulting data address
//  msr_in     in   32  current MSR
//  rfi_req    in   1   rfi in execute, held until rfi_ack
//  rfi_ack    out  1   1-cycle completion of rfi
//  spr_we     out  1   SPR write strobe
//  spr_waddr  out  10  SPR write number
//  spr_wdata  out  32  SPR write data
//  spr_raddr  out  10  SPR read number; spr_rdata is combinational, same cycle
//  spr_rdata  in   32  SPR read data
//  msr_we     out  1   MSR write strobe
//  msr_out    out  32  new MSR
//  npc_we     out  1   fetch redirect strobe
//  npc        out  32  redirect target
//  flush      out  1   flush younger instructions (TAKE cycle only)
//  busy       out  1   state != IDLE; pipeline stalls
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. Latched source index, epc, esr, dear and msr cleared.
//  - Eligible = exc_req with bit6 masked by msr_in[15] (EE). Winner = lowest eligible index.
//  - IDLE: any eligible -> TAKE (latch index, SRR0 value, msr_in, esr_in, dear_in).
//      SRR0 value = epc_next for SC/EXT, else epc.
//    Else rfi_req -> RFI0. An exception always beats a simultaneous rfi.
//  - TAKE: flush=1 -> W_SRR0.
//  - W_SRR0: write `SPRN_SRR0 <- latched SRR0 value -> W_SRR1.
//  - W_SRR1: write `SPRN_SRR1 <- latched msr -> W_ESR if src in {PROG,DTLB,DSI}, else VEC.
//  - W_ESR: write `SPRN_ESR <- latched esr -> W_DEAR if src in {DTLB,DSI}, else VEC.
//  - W_DEAR: write `SPRN_DEAR <- latched dear -> VEC.
//  - VEC: raddr=`SPRN_IVPR; latch rdata[31:16] -> JUMP.
//  - JUMP: raddr=IVOR of src.
//      npc={ivpr_hi, rdata[15:4], 4'b0}, npc_we=1
//      msr_out=latched msr & ~MSR_CLR_MASK, msr_we=1
//      exc_ack[src]=1 -> IDLE.
//  - RFI0: raddr=`SPRN_SRR0; latch rdata -> RFI1.
//  - RFI1: raddr=`SPRN_SRR1. msr_out=rdata, msr_we=1; npc=latched SRR0, npc_we=1; rfi_ack=1
//    -> IDLE.
//  - All strobes (spr_we, msr_we, npc_we, ack, flush) are single-cycle and registered
//    state-decoded. Never more than one strobe of each kind per cycle.
//  - Requests arriving or changing while busy are ignored until IDLE. The served source is the
//    one latched in TAKE, even if higher priority arrives later.
//  - A source dropping its req mid-sequence does not abort; it is still acked.
//  - Back-to-back: IDLE is always visited for >=1 cycle between sequences.
//  - rst mid-sequence: IDLE next cycle. No ack, no npc_we, no msr_we. Partial SPR writes stand.
// STRUCTURE
//  - Shared package exc_def.v: state encodings, source index macros, src->IVOR SPRN table,
//    ESR/DEAR source masks, MSR bit positions. Includes sprn_def.v for SPRN_* numbers.
//  - Sub-module exc_prio_enc: 7-bit fixed-priority encoder -> 3-bit index + valid.
// TESTING
//  1. IVPR=0xFFFF0000, IVOR6=0x0700, msr_in=0x0000C030, epc=0x100, esr_in=0x0800_0000,
//     PROG req at cycle N.
//     -> flush@N+1; SRR0=0x100@N+2; SRR1=0xC030@N+3; ESR@N+4
//     -> npc=0xFFFF0700, msr_out=0, ack[2]@N+6.
//  2. PROG and DSI raised together.
//     -> PROG fully served and acked first.
//     -> DSI taken after 1 IDLE cycle; ESR then DEAR=dear_in written; ack[5] only at its JUMP.
//  3. EXT with msr_in=0 -> no action for 20 cycles.
//     Set msr_in=0x8000 -> SRR0=epc_next, no ESR write, npc from IVOR4, msr_out=0.
//  4. rfi_req with SRR0=0x2000, SRR1=0x8000 -> npc=0x2000, msr_out=0x8000, rfi_ack 2 cycles
//     after IDLE sample.
//  5. SC and rfi_req same cycle -> SC sequence first; rfi completes after.
//     SRR0=epc_next; no ESR/DEAR writes.
//  6. rst pulsed during W_SRR1 -> IDLE next cycle; exc_ack, npc_we, msr_we stay 0; busy=0.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the exception sequencer: state encodings, source indices,
// SPR numbers, per-source behaviour masks and the source->IVOR lookup.
package exception_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_TAKE, ST_W_SRR0, ST_W_SRR1, ST_W_ESR, ST_W_DEAR,
    ST_VEC, ST_JUMP, ST_RFI0, ST_RFI1
  } state_e;

  localparam int EXC_NSRC = 7;
  localparam int SRC_W    = 3;

  localparam logic [SRC_W-1:0] SRC_ITLB = 3'd0;
  localparam logic [SRC_W-1:0] SRC_ISI  = 3'd1;
  localparam logic [SRC_W-1:0] SRC_PROG = 3'd2;
  localparam logic [SRC_W-1:0] SRC_SC   = 3'd3;
  localparam logic [SRC_W-1:0] SRC_DTLB = 3'd4;
  localparam logic [SRC_W-1:0] SRC_DSI  = 3'd5;
  localparam logic [SRC_W-1:0] SRC_EXT  = 3'd6;

  localparam logic [9:0] SPRN_SRR0  = 10'd26;
  localparam logic [9:0] SPRN_SRR1  = 10'd27;
  localparam logic [9:0] SPRN_DEAR  = 10'd61;
  localparam logic [9:0] SPRN_ESR   = 10'd62;
  localparam logic [9:0] SPRN_IVPR  = 10'd63;
  localparam logic [9:0] SPRN_IVOR0 = 10'd400;

  localparam int MSR_EE = 15;

  // Bit i set => source i needs that save / uses the next-PC as its return address
  localparam logic [EXC_NSRC-1:0] ESR_SRC_MASK    = 7'b0110100;
  localparam logic [EXC_NSRC-1:0] DEAR_SRC_MASK   = 7'b0110000;
  localparam logic [EXC_NSRC-1:0] NEXTPC_SRC_MASK = 7'b1001000;

  function automatic logic [9:0] ivor_sprn(input logic [SRC_W-1:0] src);
    logic [3:0] n;
    case (src)
      SRC_ITLB: n = 4'd14;
      SRC_ISI:  n = 4'd3;
      SRC_PROG: n = 4'd6;
      SRC_SC:   n = 4'd8;
      SRC_DTLB: n = 4'd13;
      SRC_DSI:  n = 4'd2;
      default:  n = 4'd4;
    endcase
    return SPRN_IVOR0 + {6'd0, n};
  endfunction

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module exception_ctrl_prio_enc #(
  parameter int N  = 7,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = |req_i;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i]) idx_o = IW'(i);
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencer: arbitrates sticky requests, saves SRR0/SRR1/ESR/DEAR,
// vectors through IVPR|IVORn, and executes rfi.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] MSR_CLR_MASK = 32'h0000_C030,
  parameter int          NSRC         = EXC_NSRC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] exc_req,
  output logic [NSRC-1:0] exc_ack,
  input  logic [31:0]     epc,
  input  logic [31:0]     epc_next,
  input  logic [31:0]     esr_in,
  input  logic [31:0]     dear_in,
  input  logic [31:0]     msr_in,
  input  logic            rfi_req,
  output logic            rfi_ack,
  output logic            spr_we,
  output logic [9:0]      spr_waddr,
  output logic [31:0]     spr_wdata,
  output logic [9:0]      spr_raddr,
  input  logic [31:0]     spr_rdata,
  output logic            msr_we,
  output logic [31:0]     msr_out,
  output logic            npc_we,
  output logic [31:0]     npc,
  output logic            flush,
  output logic            busy
);

  state_e            state_q, state_d;
  logic [NSRC-1:0]   elig;
  logic [SRC_W-1:0]  win_idx, src_q;
  logic              win_vld;
  logic [31:0]       srr0_q, msr_q, esr_q, dear_q;
  logic [15:0]       ivpr_hi_q;

  // External interrupts are only eligible while MSR[EE] is set
  always_comb begin
    elig          = exc_req;
    elig[SRC_EXT] = exc_req[SRC_EXT] & msr_in[MSR_EE];
  end

  exception_ctrl_prio_enc #(.N(NSRC), .IW(SRC_W)) u_prio (
    .req_i (elig),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (win_vld) state_d = ST_TAKE;
                 else if (rfi_req) state_d = ST_RFI0;
      ST_TAKE:   state_d = ST_W_SRR0;
      ST_W_SRR0: state_d = ST_W_SRR1;
      ST_W_SRR1: state_d = ESR_SRC_MASK[src_q] ? ST_W_ESR : ST_VEC;
      ST_W_ESR:  state_d = DEAR_SRC_MASK[src_q] ? ST_W_DEAR : ST_VEC;
      ST_W_DEAR: state_d = ST_VEC;
      ST_VEC:    state_d = ST_JUMP;
      ST_JUMP:   state_d = ST_IDLE;
      ST_RFI0:   state_d = ST_RFI1;
      ST_RFI1:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // srr0_q doubles as the rfi return-address holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      srr0_q    <= '0;
      msr_q     <= '0;
      esr_q     <= '0;
      dear_q    <= '0;
      ivpr_hi_q <= '0;
    end else begin
      if (state_q == ST_IDLE && win_vld) begin
        src_q  <= win_idx;
        srr0_q <= NEXTPC_SRC_MASK[win_idx] ? epc_next : epc;
        msr_q  <= msr_in;
        esr_q  <= esr_in;
        dear_q <= dear_in;
      end
      if (state_q == ST_VEC)  ivpr_hi_q <= spr_rdata[31:16];
      if (state_q == ST_RFI0) srr0_q    <= spr_rdata;
    end
  end

  always_comb begin
    exc_ack   = '0;
    rfi_ack   = 1'b0;
    spr_we    = 1'b0;
    spr_waddr = '0;
    spr_wdata = '0;
    spr_raddr = '0;
    msr_we    = 1'b0;
    msr_out   = '0;
    npc_we    = 1'b0;
    npc       = '0;
    flush     = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_TAKE:   flush = 1'b1;
      ST_W_SRR0: begin spr_we = 1'b1; spr_waddr = SPRN_SRR0; spr_wdata = srr0_q; end
      ST_W_SRR1: begin spr_we = 1'b1; spr_waddr = SPRN_SRR1; spr_wdata = msr_q;  end
      ST_W_ESR:  begin spr_we = 1'b1; spr_waddr = SPRN_ESR;  spr_wdata = esr_q;  end
      ST_W_DEAR: begin spr_we = 1'b1; spr_waddr = SPRN_DEAR; spr_wdata = dear_q; end
      ST_VEC:    spr_raddr = SPRN_IVPR;
      ST_JUMP: begin
        spr_raddr      = ivor_sprn(src_q);
        npc_we         = 1'b1;
        npc            = {ivpr_hi_q, spr_rdata[15:4], 4'b0};
        msr_we         = 1'b1;
        msr_out        = msr_q & ~MSR_CLR_MASK;
        exc_ack[src_q] = 1'b1;
      end
      ST_RFI0:   spr_raddr = SPRN_SRR0;
      ST_RFI1: begin
        spr_raddr = SPRN_SRR1;
        msr_we    = 1'b1;
        msr_out   = spr_rdata;
        npc_we    = 1'b1;
        npc       = srr0_q;
        rfi_ack   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: a transaction-level model expands each accepted
// exception/rfi into its expected output cycles; a checker compares every cycle.
module tb_exception_ctrl;

  logic        clk, rst;
  logic [6:0]  exc_req, exc_ack;
  logic [31:0] epc, epc_next, esr_in, dear_in, msr_in;
  logic        rfi_req, rfi_ack, spr_we, msr_we, npc_we, flush, busy;
  logic [9:0]  spr_waddr, spr_raddr;
  logic [31:0] spr_wdata, spr_rdata, msr_out, npc;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_ack(exc_ack),
    .epc(epc), .epc_next(epc_next), .esr_in(esr_in), .dear_in(dear_in),
    .msr_in(msr_in), .rfi_req(rfi_req), .rfi_ack(rfi_ack),
    .spr_we(spr_we), .spr_waddr(spr_waddr), .spr_wdata(spr_wdata),
    .spr_raddr(spr_raddr), .spr_rdata(spr_rdata),
    .msr_we(msr_we), .msr_out(msr_out), .npc_we(npc_we), .npc(npc),
    .flush(flush), .busy(busy)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct packed {
    logic        flush;
    logic        spr_we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        msr_we;
    logic [31:0] msr_out;
    logic        npc_we;
    logic [31:0] npc;
    logic [6:0]  ack;
    logic        rfi_ack;
    logic        busy;
  } ov_t;

  // Source index -> IVOR number (ITLB, ISI, PROG, SC, DTLB, DSI, EXT)
  localparam int IVOR_N [7] = '{14, 3, 6, 8, 13, 2, 4};

  logic [31:0] spr_img [1024];
  logic [31:0] m_srr0, m_srr1;
  ov_t         exp_mem [512];
  int          wr_ptr, rd_ptr, flush_ptr;
  int          checks, fails;
  logic        chk_en;

  assign spr_rdata = (spr_raddr == 10'd26) ? m_srr0 :
                     (spr_raddr == 10'd27) ? m_srr1 : spr_img[spr_raddr];

  function automatic ov_t wr(input logic [9:0] a, input logic [31:0] d);
    ov_t v;
    v = '0; v.busy = 1'b1; v.spr_we = 1'b1; v.waddr = a; v.wdata = d;
    return v;
  endfunction

  task automatic push(input ov_t v);
    exp_mem[wr_ptr[8:0]] = v;
    wr_ptr++;
  endtask

  task automatic gen_exc(input int w);
    ov_t b, v;
    logic [31:0] s0;
    b = '0; b.busy = 1'b1;
    v = b; v.flush = 1'b1; push(v);
    s0 = (w == 3 || w == 6) ? epc_next : epc;
    push(wr(10'd26, s0));
    push(wr(10'd27, msr_in));
    if (w == 2 || w == 4 || w == 5) push(wr(10'd62, esr_in));
    if (w == 4 || w == 5) push(wr(10'd61, dear_in));
    push(b);
    v = b;
    v.npc_we = 1'b1;
    v.npc = {spr_img[63][31:16], spr_img[400 + IVOR_N[w]][15:4], 4'h0};
    v.msr_we = 1'b1;
    v.msr_out = msr_in & ~32'h0000_C030;
    v.ack = 7'(1 << w);
    push(v);
    push('0);
    m_srr0 = s0;
    m_srr1 = msr_in;
  endtask

  task automatic gen_rfi();
    ov_t b, v;
    b = '0; b.busy = 1'b1;
    push(b);
    v = b; v.npc_we = 1'b1; v.npc = m_srr0; v.msr_we = 1'b1; v.msr_out = m_srr1; v.rfi_ack = 1'b1;
    push(v);
    push('0);
  endtask

  // Model: whenever the block is expected idle, accept the winning request
  initial begin : model
    logic [6:0] el;
    int w;
    m_srr0 = '0; m_srr1 = '0;
    forever begin
      @(posedge clk);
      if (rst) flush_ptr = wr_ptr;
      else if (rd_ptr == wr_ptr) begin
        el = exc_req;
        if (!msr_in[15]) el[6] = 1'b0;
        if (el != 7'd0) begin
          w = 0;
          while (!el[w]) w++;
          gen_exc(w);
        end else if (rfi_req) gen_rfi();
      end
    end
  end

  initial begin : chk
    ov_t e, a;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (rd_ptr < flush_ptr) rd_ptr = flush_ptr;
        e = '0;
        if (rd_ptr < wr_ptr) begin e = exp_mem[rd_ptr[8:0]]; rd_ptr++; end
        a = '0;
        a.flush = flush; a.spr_we = spr_we; a.msr_we = msr_we; a.npc_we = npc_we;
        a.ack = exc_ack; a.rfi_ack = rfi_ack; a.busy = busy;
        if (e.spr_we) begin a.waddr = spr_waddr; a.wdata = spr_wdata; end
        if (e.msr_we) a.msr_out = msr_out;
        if (e.npc_we) a.npc = npc;
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL cycle_model t=%0t dut=%h exp=%h", $time, a, e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    exc_req = exc_req & ~exc_ack;
    if (rfi_ack) rfi_req = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (n < 300 && !(rd_ptr == wr_ptr && exc_req == 7'd0 && !rfi_req && !busy)) begin
      step(); n++;
    end
    checks++;
    if (n >= 300) begin fails++; $display("FAIL %s: timeout waiting for idle", nm); end
  endtask

  task automatic wait_for_ack(output int n);
    n = 0;
    while (exc_ack == 7'd0 && n < 60) begin step(); n++; end
  endtask

  initial begin : stim
    int n;
    rst = 1'b1; chk_en = 1'b0; exc_req = '0; rfi_req = 1'b0;
    epc = '0; epc_next = '0; esr_in = '0; dear_in = '0; msr_in = '0;
    for (int i = 0; i < 1024; i++) spr_img[i] = '0;
    spr_img[63]  = 32'hFFFF_0000;
    spr_img[402] = 32'h000F_030F;   // junk outside [15:4] must be dropped
    spr_img[403] = 32'h0000_0400;
    spr_img[404] = 32'h0000_0500;
    spr_img[406] = 32'h0000_0700;
    spr_img[408] = 32'h0000_0C00;
    spr_img[413] = 32'h0000_0D00;
    spr_img[414] = 32'h0000_0E00;
    repeat (3) step();
    rst = 1'b0; chk_en = 1'b1;
    step();
    lit("reset_strobes", {flush, spr_we, msr_we, npc_we, rfi_ack, busy, exc_ack}, 64'd0);
    lit("reset_data", {npc, msr_out}, 64'd0);

    // 1: PROG with exact cycle timing
    msr_in = 32'h0000_C030; epc = 32'h100; epc_next = 32'h104;
    esr_in = 32'h0800_0000; dear_in = 32'hDEAD_0000;
    step(); exc_req[2] = 1'b1;
    step(); lit("t1_flush", {flush, busy}, 2'b11);
    step(); lit("t1_srr0", {spr_we, spr_waddr, spr_wdata}, {1'b1, 10'd26, 32'h100});
    step(); lit("t1_srr1", {spr_we, spr_waddr, spr_wdata}, {1'b1, 10'd27, 32'h0000_C030});
    step(); lit("t1_esr",  {spr_we, spr_waddr, spr_wdata}, {1'b1, 10'd62, 32'h0800_0000});
    step(); lit("t1_vec",  {spr_we, msr_we, npc_we, exc_ack}, 64'd0);
    step();
    lit("t1_npc", {npc_we, npc}, {1'b1, 32'hFFFF_0700});
    lit("t1_msr", {msr_we, msr_out}, {1'b1, 32'h0});
    lit("t1_ack", exc_ack, 7'b0000100);
    wait_done("t1");

    // 2: PROG and DSI together
    msr_in = 32'h0; epc = 32'h200; esr_in = 32'h0080_0000; dear_in = 32'h1234_5678;
    step(); exc_req = 7'b0100100;
    wait_for_ack(n);
    lit("t2_first_ack", exc_ack, 7'b0000100);
    n = 0;
    while (!(spr_we && spr_waddr == 10'd61) && n < 60) begin step(); n++; end
    lit("t2_dear", spr_wdata, 32'h1234_5678);
    wait_done("t2");

    // 3: EXT masked by EE, then enabled
    msr_in = 32'h0; epc = 32'h300; epc_next = 32'h304;
    step(); exc_req[6] = 1'b1;
    repeat (20) step();
    lit("t3_masked", {busy, exc_ack}, 64'd0);
    msr_in = 32'h0000_8000;
    n = 0;
    while (!npc_we && n < 60) begin step(); n++; end
    lit("t3_npc", npc, 32'hFFFF_0500);
    lit("t3_msr", msr_out, 32'h0);
    wait_done("t3");

    // 4: exception saves SRR0=0x2000/SRR1=0x8000, then rfi returns there
    msr_in = 32'h0000_8000; epc = 32'h2000; esr_in = 32'h1;
    step(); exc_req[2] = 1'b1;
    wait_done("t4_exc");
    step(); rfi_req = 1'b1;
    step(); lit("t4_rfi0", {busy, npc_we, rfi_ack}, 3'b100);
    step();
    lit("t4_rfi_ack", rfi_ack, 1'b1);
    lit("t4_npc", npc, 32'h2000);
    lit("t4_msr", msr_out, 32'h0000_8000);
    wait_done("t4");

    // 5: SC and rfi in the same cycle
    msr_in = 32'h0000_0030; epc = 32'h400; epc_next = 32'h404;
    step(); exc_req[3] = 1'b1; rfi_req = 1'b1;
    wait_for_ack(n);
    lit("t5_sc_ack", {exc_ack, rfi_ack}, {7'b0001000, 1'b0});
    n = 0;
    while (!rfi_ack && n < 60) begin step(); n++; end
    lit("t5_rfi_npc", npc, 32'h404);
    lit("t5_rfi_msr", msr_out, 32'h0000_0030);
    wait_done("t5");

    // 7: late higher-priority arrival and a dropped request
    msr_in = 32'h0000_8000; epc = 32'h600; esr_in = 32'h0040_0000; dear_in = 32'hCAFE_0000;
    step(); exc_req[4] = 1'b1;
    step(); step(); exc_req[0] = 1'b1; exc_req[4] = 1'b0;
    wait_for_ack(n);
    lit("t7_first_ack", exc_ack, 7'b0010000);
    wait_done("t7");

    // 2b: DSI vector uses only IVOR bits [15:4]
    msr_in = 32'h0; epc = 32'h700;
    step(); exc_req[5] = 1'b1;
    n = 0;
    while (!npc_we && n < 60) begin step(); n++; end
    lit("t2b_npc", npc, 32'hFFFF_0300);
    wait_done("t2b");

    // 6: reset during W_SRR1
    msr_in = 32'h0000_C030; epc = 32'h500;
    step(); exc_req[2] = 1'b1;
    step(); step(); step();
    lit("t6_in_srr1", {spr_we, spr_waddr}, {1'b1, 10'd27});
    rst = 1'b1; exc_req = '0;
    step();
    lit("t6_after_rst", {busy, npc_we, msr_we, exc_ack}, 64'd0);
    rst = 1'b0;
    repeat (6) step();
    lit("t6_quiet", {busy, npc_we, msr_we, exc_ack}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
